mmio_router: RTL and testbench

Routes the CPU memory stage's single outstanding load/store request either to the core-local timer (CLINT) register port or to the AXI-facing memory port, based on address. It sits directly upstream of the CLINT. It generates the CLINT's one-cycle read/write enables, waits for the CLINT's registered read data or write acknowledge, and returns a uniform one-cycle response to the memory stage.

---
 rtl/mmio_router_pkg.sv | 31 +++
 rtl/mmio_router.sv | 146 ++++++++++++++
 tb/tb_mmio_router.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_router_pkg.sv
// Shared constants, the latched request record and the CLINT region decode
// used by the memory-stage MMIO router.
package mmio_router_pkg;

    localparam int WORD_BUS = 64;

    localparam logic TRUE_V  = 1'b1;
    localparam logic FALSE_V = 1'b0;

    localparam logic [WORD_BUS-1:0] ZERO_WORD = '0;

    localparam logic [63:0] DEFAULT_CLINT_BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] MTIME_ADDR         = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] MTIMECMP_ADDR      = 64'h0000_0000_0200_4000;

    // The CLINT occupies one 64 KiB window; only the bits above it are decoded.
    localparam int CLINT_REGION_BITS = 16;

    typedef struct packed {
        logic                we;
        logic [63:0]         addr;
        logic [WORD_BUS-1:0] wdata;
        logic [7:0]          wmask;
    } mmio_req_t;

    function automatic logic in_clint_region(input logic [63:0] addr,
                                             input logic [63:0] base);
        return addr[63:CLINT_REGION_BITS] == base[63:CLINT_REGION_BITS];
    endfunction

endpackage

// File: rtl/mmio_router.sv
// Steers the memory stage's single outstanding load/store to the CLINT register
// port or to the memory port, and returns a uniform one-cycle response.
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter logic [63:0] CLINT_BASE = DEFAULT_CLINT_BASE
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [63:0]         req_addr,
    input  logic [WORD_BUS-1:0] req_wdata,
    input  logic [7:0]          req_wmask,
    output logic                resp_valid,
    output logic [WORD_BUS-1:0] resp_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [63:0]         mem_addr,
    output logic [WORD_BUS-1:0] mem_wdata,
    output logic [7:0]          mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [WORD_BUS-1:0] mem_resp_rdata,

    output logic                clint_read_en,
    output logic [63:0]         clint_read_addr,
    input  logic [WORD_BUS-1:0] clint_data_read,
    output logic                clint_write_en,
    output logic [63:0]         clint_write_addr,
    output logic [WORD_BUS-1:0] clint_data_write,
    input  logic                clint_write_isdone
);

    typedef enum logic [2:0] {
        IDLE,
        CLINT_ACC,
        CLINT_RESP,
        MEM_REQ,
        MEM_WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    mmio_req_t           req_q;
    logic [WORD_BUS-1:0] rdata_q;
    logic                accept;

    assign accept = (state == IDLE) && req_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the request latch is reset because its fields drive the CLINT and
    // memory ports directly, which must read as zero out of reset.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
        end
    end

    // Stores never touch the returned data; it holds the last load's value.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            rdata_q <= ZERO_WORD;
        end else if ((state == CLINT_RESP) && !req_q.we) begin
            rdata_q <= clint_data_read;
        end else if ((state == MEM_WAIT) && mem_resp_valid && !req_q.we) begin
            rdata_q <= mem_resp_rdata;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        req_ready      = FALSE_V;
        resp_valid     = FALSE_V;
        mem_req_valid  = FALSE_V;
        clint_read_en  = FALSE_V;
        clint_write_en = FALSE_V;

        case (state)
            IDLE: begin
                req_ready = TRUE_V;
                if (req_valid) begin
                    state_nxt = in_clint_region(req_addr, CLINT_BASE) ? CLINT_ACC : MEM_REQ;
                end
            end
            CLINT_ACC: begin
                clint_read_en  = !req_q.we;
                clint_write_en = req_q.we;
                state_nxt      = CLINT_RESP;
            end
            CLINT_RESP: begin
                // Only an MTIMECMP store is acknowledged; everything else completes now.
                if (!req_q.we || (req_q.addr != MTIMECMP_ADDR) || clint_write_isdone) begin
                    state_nxt = DONE;
                end
            end
            MEM_REQ: begin
                mem_req_valid = TRUE_V;
                if (mem_req_ready) begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = TRUE_V;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign resp_rdata       = rdata_q;

    assign mem_we           = req_q.we;
    assign mem_addr         = req_q.addr;
    assign mem_wdata        = req_q.wdata;
    assign mem_wmask        = req_q.wmask;

    assign clint_read_addr  = req_q.addr;
    assign clint_write_addr = req_q.addr;
    assign clint_data_write = req_q.wdata;

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: CLINT and memory responder models,
// directed vector table, hand-written reset/spurious sequences, random traffic.
module tb_mmio_router;
    import mmio_router_pkg::*;

    logic        cpu_clk_50M;
    logic        cpu_rst_n;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        clint_read_en, clint_write_en, clint_write_isdone;
    logic [63:0] clint_read_addr, clint_data_read, clint_write_addr, clint_data_write;

    mmio_router #(.CLINT_BASE(DEFAULT_CLINT_BASE)) dut (
        .cpu_clk_50M        (cpu_clk_50M),
        .cpu_rst_n          (cpu_rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_wmask          (req_wmask),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wmask          (mem_wmask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_rdata     (mem_resp_rdata),
        .clint_read_en      (clint_read_en),
        .clint_read_addr    (clint_read_addr),
        .clint_data_read    (clint_data_read),
        .clint_write_en     (clint_write_en),
        .clint_write_addr   (clint_write_addr),
        .clint_data_write   (clint_data_write),
        .clint_write_isdone (clint_write_isdone)
    );

    initial begin
        cpu_clk_50M = 1'b0;
        forever #5 cpu_clk_50M = ~cpu_clk_50M;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CLINT environment: free-running mtime, mtimecmp, registered read data,
    // write acknowledge isdone_delay cycles after an MTIMECMP write.
    logic [63:0] mtime, mtimecmp, clint_rd_q;
    int          isdone_cnt, isdone_delay;

    // Memory environment: sparse image, ready stall and response latency.
    logic [63:0] mem_img [logic [63:0]];
    int          mem_stall_left, mem_lat_cfg, mem_lat_left;
    bit          mem_busy, spurious_cfg;
    mmio_req_t   mem_pend;
    logic [63:0] mem_rd_pending;

    // Per-transaction monitor state.
    int          cyc, n_rd, n_wr, n_memv, n_resp, first_resp_cyc, field_err, ready_err;
    bit          busy_win;
    logic [63:0] resp_rdata_at, last_rdata;
    mmio_req_t   exp_req;

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 64'h0;
    endfunction

    function automatic logic [63:0] clint_value(input logic [63:0] a);
        if (a == MTIME_ADDR) return mtime;
        if (a == MTIMECMP_ADDR) return mtimecmp;
        return 64'h0;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic        rd_s, wr_s, mv_s, hs_s;
        logic [63:0] ra_s, wa_s, wd_s, old;
        mmio_req_t   mf_s;
        clint_data_read    = clint_rd_q;
        clint_write_isdone = (isdone_cnt == 1);
        mem_req_ready      = mem_req_valid && (mem_stall_left == 0);
        mem_resp_valid     = 1'b0;
        mem_resp_rdata     = 64'h0;
        if (mem_busy && mem_lat_left == 1) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = mem_rd_pending;
        end else if (spurious_cfg && mem_req_valid && mem_stall_left == 1) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        rd_s = clint_read_en;
        wr_s = clint_write_en;
        mv_s = mem_req_valid;
        hs_s = mem_req_valid && mem_req_ready;
        ra_s = clint_read_addr;
        wa_s = clint_write_addr;
        wd_s = clint_data_write;
        mf_s = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wmask: mem_wmask};
        if (rd_s) begin
            n_rd++;
            if (ra_s !== exp_req.addr) field_err++;
        end
        if (wr_s) begin
            n_wr++;
            if (wa_s !== exp_req.addr || wd_s !== exp_req.wdata) field_err++;
        end
        if (mv_s) begin
            n_memv++;
            if (mf_s !== exp_req) field_err++;
        end
        if (busy_win && n_resp == 0 && req_ready) ready_err++;
        if (resp_valid) begin
            n_resp++;
            if (n_resp == 1) begin
                first_resp_cyc = cyc;
                resp_rdata_at  = resp_rdata;
            end
        end

        @(posedge cpu_clk_50M);
        if (isdone_cnt != 0) isdone_cnt--;
        if (rd_s) clint_rd_q = clint_value(ra_s);
        if (wr_s && wa_s == MTIMECMP_ADDR) begin
            mtimecmp   = wd_s;
            isdone_cnt = isdone_delay;
        end
        if (wr_s && wa_s == MTIME_ADDR) mtime = wd_s;
        else mtime = mtime + 64'd1;
        if (mem_busy) begin
            if (mem_lat_left == 1) begin
                mem_busy = 1'b0;
                if (mem_pend.we) begin
                    old = mem_read(mem_pend.addr);
                    for (int b = 0; b < 8; b++)
                        if (mem_pend.wmask[b]) old[8*b +: 8] = mem_pend.wdata[8*b +: 8];
                    mem_img[mem_pend.addr] = old;
                end
            end else begin
                mem_lat_left--;
            end
        end
        if (hs_s) begin
            mem_busy       = 1'b1;
            mem_lat_left   = mem_lat_cfg;
            mem_pend       = mf_s;
            mem_rd_pending = mem_read(mf_s.addr);
        end else if (mv_s && mem_stall_left > 0) begin
            mem_stall_left--;
        end
        cyc++;
        @(negedge cpu_clk_50M);
    endtask

    task automatic clear_monitor();
        n_rd = 0; n_wr = 0; n_memv = 0; n_resp = 0;
        first_resp_cyc = -1; field_err = 0; ready_err = 0;
        resp_rdata_at = 64'h0;
    endtask

    // Spec-level prediction: CLINT accesses take 3 cycles (MTIMECMP stores 2 +
    // ack delay); memory takes 2 + stall + response delay.
    task automatic ref_predict(input mmio_req_t r, input int stall, input int lat, input int isd,
                               output int exp_lat, output logic [63:0] exp_rdata);
        logic [63:0] base;
        base = DEFAULT_CLINT_BASE;
        if (r.addr[63:16] == base[63:16]) begin
            exp_lat = (r.we && r.addr == MTIMECMP_ADDR) ? 2 + isd : 3;
            if (r.we) exp_rdata = last_rdata;
            else if (r.addr == MTIME_ADDR) exp_rdata = mtime + 64'd1;
            else if (r.addr == MTIMECMP_ADDR) exp_rdata = mtimecmp;
            else exp_rdata = 64'h0;
        end else begin
            exp_lat   = 2 + stall + lat;
            exp_rdata = r.we ? last_rdata : mem_read(r.addr);
        end
    endtask

    task automatic do_txn(input string name, input mmio_req_t r, input int stall, input int lat,
                          input int isd, input bit spur, input int exp_lat,
                          input logic [63:0] exp_rdata);
        logic [63:0] base;
        bit          hit;
        int          t_acc;
        base = DEFAULT_CLINT_BASE;
        hit  = (r.addr[63:16] == base[63:16]);
        clear_monitor();
        exp_req        = r;
        mem_stall_left = stall;
        mem_lat_cfg    = lat;
        isdone_delay   = isd;
        spurious_cfg   = spur;
        check({name, " ready_idle"}, 64'(req_ready), 64'd1);
        t_acc     = cyc;
        req_valid = 1'b1;
        req_we    = r.we;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        req_wmask = r.wmask;
        step();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'($urandom);
        busy_win  = 1'b1;
        while (n_resp == 0 && cyc - t_acc < 80) step();
        busy_win = 1'b0;
        spurious_cfg = 1'b0;
        check({name, " resp_seen"}, 64'(n_resp), 64'd1);
        check({name, " latency"}, 64'(first_resp_cyc - t_acc), 64'(exp_lat));
        check({name, " rdata"}, resp_rdata_at, exp_rdata);
        check({name, " clint_rd_pulses"}, 64'(n_rd), 64'(hit && !r.we));
        check({name, " clint_wr_pulses"}, 64'(n_wr), 64'(hit && r.we));
        check({name, " mem_valid_cycles"}, 64'(n_memv), hit ? 64'd0 : 64'(stall + 1));
        check({name, " field_stability"}, 64'(field_err), 64'd0);
        check({name, " ready_low_busy"}, 64'(ready_err), 64'd0);
        check({name, " ready_after"}, 64'(req_ready), 64'd1);
        check({name, " resp_single"}, 64'(resp_valid), 64'd0);
        last_rdata = exp_rdata;
    endtask

    typedef enum {RD_CONST, RD_KEEP, RD_MTIME} rd_kind_e;

    typedef struct {
        string       name;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          stall;
        int          lat;
        int          isd;
        bit          spur;
        int          exp_lat;
        rd_kind_e    kind;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    initial begin
        mmio_req_t   r;
        int          e_lat;
        logic [63:0] e_rd;
        int          sel;

        vecs[0]  = '{"ld_mtime",       0, MTIME_ADDR,    64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_MTIME, 64'h0};
        vecs[1]  = '{"st_mtimecmp",    1, MTIMECMP_ADDR, 64'h1000, 8'hFF, 0, 1, 1, 0, 3, RD_KEEP, 64'h0};
        vecs[2]  = '{"ld_mtimecmp",    0, MTIMECMP_ADDR, 64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_CONST, 64'h1000};
        vecs[3]  = '{"st_cmp_late",    1, MTIMECMP_ADDR, 64'h2222, 8'hFF, 0, 1, 3, 0, 5, RD_KEEP, 64'h0};
        vecs[4]  = '{"ld_cmp2",        0, MTIMECMP_ADDR, 64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_CONST, 64'h2222};
        vecs[5]  = '{"st_unmapped",    1, 64'h0200_0008, 64'h5555, 8'h01, 0, 1, 1, 0, 3, RD_KEEP, 64'h0};
        vecs[6]  = '{"ld_unmapped",    0, 64'h0200_0008, 64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_CONST, 64'h0};
        vecs[7]  = '{"ld_cmp_kept",    0, MTIMECMP_ADDR, 64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_CONST, 64'h2222};
        vecs[8]  = '{"st_mem",         1, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 1, 1, 0, 3, RD_KEEP, 64'h0};
        vecs[9]  = '{"ld_mem_stall",   0, 64'h8000_0000, 64'h0,  8'hFF, 3, 2, 1, 0, 7, RD_CONST, 64'hDEAD_BEEF_0123_4567};
        vecs[10] = '{"st_mem_mask",    1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1, 1, 1, 0, 4, RD_KEEP, 64'h0};
        vecs[11] = '{"ld_mem_spur",    0, 64'h8000_0000, 64'h0,  8'hFF, 2, 1, 1, 1, 5, RD_CONST, 64'hDEAD_BEEF_FFFF_FFFF};
        vecs[12] = '{"st_mtime",       1, MTIME_ADDR,    64'h500, 8'hFF, 0, 1, 1, 0, 3, RD_KEEP, 64'h0};
        vecs[13] = '{"ld_mtime2",      0, MTIME_ADDR,    64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_MTIME, 64'h0};
        vecs[14] = '{"ld_above_clint", 0, 64'h0201_0000, 64'h0,  8'hFF, 0, 1, 1, 0, 3, RD_CONST, 64'h0};

        cpu_rst_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        clint_data_read = '0; clint_write_isdone = 1'b0;
        mtime = 64'h100; mtimecmp = '1; clint_rd_q = '0; isdone_cnt = 0; isdone_delay = 1;
        mem_busy = 1'b0; mem_stall_left = 0; mem_lat_cfg = 1; mem_lat_left = 0;
        spurious_cfg = 1'b0; mem_pend = '0; mem_rd_pending = '0;
        cyc = 0; busy_win = 1'b0; last_rdata = '0; exp_req = '0;
        clear_monitor();

        #2 cpu_rst_n = 1'b0;
        #1;
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_rdata", resp_rdata, 64'h0);
        check("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst mem_fields", {mem_addr ^ mem_wdata, 55'h0, mem_we, mem_wmask}, 64'h0);
        check("rst clint_en", 64'({clint_read_en, clint_write_en}), 64'd0);
        check("rst clint_fields", clint_read_addr | clint_write_addr | clint_data_write, 64'h0);
        @(negedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk_50M);

        for (int i = 0; i < 15; i++) begin
            r = '{we: vecs[i].we, addr: vecs[i].addr, wdata: vecs[i].wdata, wmask: vecs[i].wmask};
            case (vecs[i].kind)
                RD_MTIME: e_rd = mtime + 64'd1;
                RD_KEEP:  e_rd = last_rdata;
                default:  e_rd = vecs[i].exp_rdata;
            endcase
            do_txn(vecs[i].name, r, vecs[i].stall, vecs[i].lat, vecs[i].isd, vecs[i].spur,
                   vecs[i].exp_lat, e_rd);
        end

        // Reset while a load waits in MEM_WAIT: everything drops at once and the
        // pending response never surfaces.
        clear_monitor();
        exp_req = '{we: 1'b0, addr: 64'h8000_0040, wdata: 64'h0, wmask: 8'hFF};
        mem_stall_left = 0; mem_lat_cfg = 6;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0040; req_wdata = '0; req_wmask = 8'hFF;
        step();
        req_valid = 1'b0;
        step();
        check("mw mem_req_dropped", 64'(mem_req_valid), 64'd0);
        check("mw ready_low", 64'(req_ready), 64'd0);
        cpu_rst_n = 1'b0;
        #1;
        check("mw rst req_ready", 64'(req_ready), 64'd1);
        check("mw rst resp_valid", 64'(resp_valid), 64'd0);
        check("mw rst resp_rdata", resp_rdata, 64'h0);
        check("mw rst mem_addr", mem_addr, 64'h0);
        check("mw rst enables", 64'({mem_req_valid, clint_read_en, clint_write_en}), 64'd0);
        mem_busy = 1'b0;
        step();
        step();
        cpu_rst_n = 1'b1;
        step();
        check("mw no_stale_resp", 64'(n_resp), 64'd0);
        last_rdata = 64'h0;
        r = '{we: 1'b0, addr: 64'h8000_0000, wdata: 64'h0, wmask: 8'hFF};
        ref_predict(r, 1, 1, 1, e_lat, e_rd);
        do_txn("post_rst_ld", r, 1, 1, 1, 0, e_lat, e_rd);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       r.addr = MTIME_ADDR;
                1:       r.addr = MTIMECMP_ADDR;
                2:       r.addr = DEFAULT_CLINT_BASE + {45'h0, 16'($urandom_range(0, 8191)), 3'b000};
                3:       r.addr = 64'h8000_0000 + {57'h0, 4'($urandom_range(0, 15)), 3'b000};
                4:       r.addr = 64'h0201_0000;
                default: r.addr = 64'h01FF_FFF8;
            endcase
            r.we    = 1'($urandom_range(0, 1));
            r.wdata = {$urandom, $urandom};
            r.wmask = 8'($urandom_range(0, 255));
            begin
                int st, lt, id;
                st = $urandom_range(0, 3);
                lt = $urandom_range(1, 3);
                id = $urandom_range(1, 3);
                ref_predict(r, st, lt, id, e_lat, e_rd);
                do_txn($sformatf("rnd%0d", i), r, st, lt, id, 0, e_lat, e_rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
